hazard_ctrl: RTL

Central stall/flush/forwarding controller for the 5-stage PipelineCPU. It detects RAW and load-use hazards between ID and the EX/MEM/WB stages, and selects the forwarding sources for the EX operands. It sequences pipeline freezes while the data memory is busy and flushes wrong-path instructions on a taken branch. It sits beside the stage registers and drives their enable and flush inputs plus the EX operand muxes.

---
 rtl/hazard_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Define FORWARD_EN to forward EX operands; otherwise EX/MEM producers stall until they reach WB.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REG_W   = 5;
    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_WB  = 2'b01;
    localparam logic [1:0]  FWD_MEM = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_stall;
    logic raw_hazard;

    // A producer matches a consumer only if it writes a nonzero rd equal to the source.
    function automatic logic src_match(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             wr,
        input logic [REG_W-1:0] rd
    );
        return use_rs && wr && (rd != '0) && (rd == rs);
    endfunction

    assign mem_stall = (state == MEM_WAIT) || (mem_req && !mem_ready);

`ifdef FORWARD_EN
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             m_wr,
        input logic [REG_W-1:0] m_rd,
        input logic             w_wr,
        input logic [REG_W-1:0] w_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src_match(1'b1, rs, m_wr, m_rd)) begin
            sel = FWD_MEM;
        end else if (src_match(1'b1, rs, w_wr, w_rd)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Only a load in EX cannot be forwarded in time.
    assign raw_hazard = ex_mem_read &&
                        (src_match(id_use_rs1, id_rs1, ex_reg_write, ex_rd) ||
                         src_match(id_use_rs2, id_rs2, ex_reg_write, ex_rd));

    // Source fields of the instruction now in EX; they hold while ID/EX is frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (id_ex_flush) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (id_ex_en) begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (rst) begin
            fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
            fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        end
    end
`else
    logic unused_fwd_inputs;

    // Without forwarding, any EX or MEM producer stalls ID; WB is covered by write-before-read.
    assign raw_hazard = src_match(id_use_rs1, id_rs1, ex_reg_write,  ex_rd)  ||
                        src_match(id_use_rs2, id_rs2, ex_reg_write,  ex_rd)  ||
                        src_match(id_use_rs1, id_rs1, mem_reg_write, mem_rd) ||
                        src_match(id_use_rs2, id_rs2, mem_reg_write, mem_rd);

    assign unused_fwd_inputs = ^{ex_mem_read, wb_rd, wb_reg_write};
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Priority: memory stall, then taken branch, then RAW/load-use.
    always_comb begin
        state_next   = state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;

        case (state)
            RUN:      if (mem_req && !mem_ready) state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready)             state_next = RUN;
        endcase

        if (rst) begin
            if (mem_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (ex_br_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (raw_hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_flush  = 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
